// File: rtl/stage_id_pipe_if.sv
// ID/EX pipeline bus: registered decode payload plus the valid/ready handshake to EX.
interface stage_id_pipe_if #(
   parameter int REG_ADDR_WIDTH = 5,
   parameter int REG_WIDTH      = 32,
   parameter int PC_WIDTH       = 32
);
   logic                      id_ex_valid;
   logic                      ex_ready;
   logic [PC_WIDTH-1:0]       id_ex_pc;
   logic [REG_WIDTH-1:0]      id_ex_rs1_data;
   logic [REG_WIDTH-1:0]      id_ex_rs2_data;
   logic [REG_WIDTH-1:0]      id_ex_imm;
   logic [REG_ADDR_WIDTH-1:0] id_ex_rd;
   logic [3:0]                id_ex_funct;
   logic [5:0]                id_ex_ctrl;

   // ID side: produces the payload, observes EX backpressure.
   modport master (
      output id_ex_valid, id_ex_pc, id_ex_rs1_data, id_ex_rs2_data,
             id_ex_imm, id_ex_rd, id_ex_funct, id_ex_ctrl,
      input  ex_ready
   );

   // EX side: consumes the payload, signals when it can take it.
   modport slave (
      input  id_ex_valid, id_ex_pc, id_ex_rs1_data, id_ex_rs2_data,
             id_ex_imm, id_ex_rd, id_ex_funct, id_ex_ctrl,
      output ex_ready
   );
endinterface

// File: rtl/stage_id_pipe.sv
// RV32I instruction-decode stage: register file with write-through bypass,
// immediate generation, operand forwarding, branch/jump resolution in ID,
// load-use stall, registered ID/EX stage and a saturating stall counter.
// Control word layout: {reg_wr, mem_wr, mem_rd, alu_src_imm, wb_sel[1:0]},
// wb_sel: 00 ALU result, 01 load data, 10 pc+4, 11 pc+imm (AUIPC).
module stage_id_pipe #(
   parameter int NUM_REG         = 32,
   parameter int REG_ADDR_WIDTH  = 5,
   parameter int REG_WIDTH       = 32,
   parameter int PC_WIDTH        = 32,
   parameter int INST_WIDTH      = 32,
   parameter int STALL_CNT_WIDTH = 16
) (
   input  logic                       clk,
   input  logic                       reset_n,
   // IF/ID side
   input  logic                       if_valid,
   output logic                       id_ready,
   input  logic [PC_WIDTH-1:0]        if_pc,
   input  logic [INST_WIDTH-1:0]      if_inst,
   // MEM/WB write port
   input  logic                       wb_wr_en,
   input  logic [REG_ADDR_WIDTH-1:0]  wb_rd,
   input  logic [REG_WIDTH-1:0]       wb_data,
   // forwarding
   input  logic [1:0]                 fwd_sel1,
   input  logic [1:0]                 fwd_sel2,
   input  logic [REG_WIDTH-1:0]       ex_fwd_data,
   input  logic [REG_WIDTH-1:0]       mem_fwd_data,
   // hazard inputs from the instruction in ID/EX
   input  logic                       ex_is_load,
   input  logic [REG_ADDR_WIDTH-1:0]  ex_rd,
   // fetch redirect
   output logic                       pc_sel,
   output logic [PC_WIDTH-1:0]        pc_target,
   // ID/EX bus
   stage_id_pipe_if.master            id_ex_bus,
   output logic [STALL_CNT_WIDTH-1:0] stall_cnt
);

   localparam logic [6:0] OPC_OP     = 7'b0110011;
   localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
   localparam logic [6:0] OPC_LOAD   = 7'b0000011;
   localparam logic [6:0] OPC_STORE  = 7'b0100011;
   localparam logic [6:0] OPC_BRANCH = 7'b1100011;
   localparam logic [6:0] OPC_JAL    = 7'b1101111;
   localparam logic [6:0] OPC_JALR   = 7'b1100111;
   localparam logic [6:0] OPC_LUI    = 7'b0110111;
   localparam logic [6:0] OPC_AUIPC  = 7'b0010111;

   localparam logic [1:0] WB_ALU   = 2'b00;
   localparam logic [1:0] WB_MEM   = 2'b01;
   localparam logic [1:0] WB_PC4   = 2'b10;
   localparam logic [1:0] WB_PCIMM = 2'b11;

   typedef enum logic [2:0] {IMM_NONE, IMM_I, IMM_S, IMM_B, IMM_U, IMM_J} imm_type_e;

   typedef struct packed {
      logic       reg_wr;
      logic       mem_wr;
      logic       mem_rd;
      logic       alu_src_imm;
      logic [1:0] wb_sel;
   } ctrl_t;

   typedef struct packed {
      logic                      valid;
      logic [PC_WIDTH-1:0]       pc;
      logic [REG_WIDTH-1:0]      rs1_data;
      logic [REG_WIDTH-1:0]      rs2_data;
      logic [REG_WIDTH-1:0]      imm;
      logic [REG_ADDR_WIDTH-1:0] rd;
      logic [3:0]                funct;
      ctrl_t                     ctrl;
   } id_ex_t;

   // instruction fields
   logic [6:0]                opcode;
   logic [2:0]                funct3;
   logic [REG_ADDR_WIDTH-1:0] rs1;
   logic [REG_ADDR_WIDTH-1:0] rs2;

   assign opcode = if_inst[6:0];
   assign funct3 = if_inst[14:12];
   assign rs1    = if_inst[19:15];
   assign rs2    = if_inst[24:20];

   // decode results
   imm_type_e                 imm_type;
   ctrl_t                     dec_ctrl;
   logic                      rs1_used;
   logic                      rs2_used;
   logic                      is_branch;
   logic                      is_jal;
   logic                      is_jalr;
   logic [31:0]               imm32;
   logic [REG_WIDTH-1:0]      dec_imm;
   logic [REG_ADDR_WIDTH-1:0] dec_rd;

   // register file and operands
   logic [REG_WIDTH-1:0] regs_q [NUM_REG];
   logic [REG_WIDTH-1:0] regs_d [NUM_REG];
   logic [REG_WIDTH-1:0] rf_rs1;
   logic [REG_WIDTH-1:0] rf_rs2;
   logic [REG_WIDTH-1:0] rs1v;
   logic [REG_WIDTH-1:0] rs2v;

   // branch, handshake, state
   logic                       br_taken;
   logic [REG_WIDTH-1:0]       jalr_sum;
   logic                       adv;
   logic                       load_use;
   logic                       transfer;
   id_ex_t                     id_ex_q;
   id_ex_t                     id_ex_d;
   logic [STALL_CNT_WIDTH-1:0] stall_cnt_q;
   logic [STALL_CNT_WIDTH-1:0] stall_cnt_d;

   // Operand mux: regfile (bypassed), EX/MEM result, DMEM data, or WB data.
   function automatic logic [REG_WIDTH-1:0] fwd_mux(input logic [1:0] sel,
                                                    input logic [REG_WIDTH-1:0] rf_val);
      case (sel)
         2'b00:   return rf_val;
         2'b01:   return ex_fwd_data;
         2'b10:   return mem_fwd_data;
         default: return wb_data;
      endcase
   endfunction

   // Opcode decode: immediate format, control word and which sources are read.
   always_comb begin
      // NOTE: every output of this block gets a default before the case, so no
      // path leaves one unassigned; a missed assignment would infer a latch.
      imm_type  = IMM_NONE;
      dec_ctrl  = '0;
      rs1_used  = 1'b0;
      rs2_used  = 1'b0;
      is_branch = 1'b0;
      is_jal    = 1'b0;
      is_jalr   = 1'b0;
      case (opcode)
         OPC_OP: begin
            dec_ctrl = '{1'b1, 1'b0, 1'b0, 1'b0, WB_ALU};
            rs1_used = 1'b1;
            rs2_used = 1'b1;
         end
         OPC_OP_IMM: begin
            imm_type = IMM_I;
            dec_ctrl = '{1'b1, 1'b0, 1'b0, 1'b1, WB_ALU};
            rs1_used = 1'b1;
         end
         OPC_LOAD: begin
            imm_type = IMM_I;
            dec_ctrl = '{1'b1, 1'b0, 1'b1, 1'b1, WB_MEM};
            rs1_used = 1'b1;
         end
         OPC_STORE: begin
            imm_type = IMM_S;
            dec_ctrl = '{1'b0, 1'b1, 1'b0, 1'b1, WB_ALU};
            rs1_used = 1'b1;
            rs2_used = 1'b1;
         end
         OPC_BRANCH: begin
            imm_type  = IMM_B;
            rs1_used  = 1'b1;
            rs2_used  = 1'b1;
            is_branch = 1'b1;
         end
         OPC_JAL: begin
            imm_type = IMM_J;
            dec_ctrl = '{1'b1, 1'b0, 1'b0, 1'b0, WB_PC4};
            is_jal   = 1'b1;
         end
         OPC_JALR: begin
            imm_type = IMM_I;
            dec_ctrl = '{1'b1, 1'b0, 1'b0, 1'b1, WB_PC4};
            rs1_used = 1'b1;
            is_jalr  = 1'b1;
         end
         OPC_LUI: begin
            imm_type = IMM_U;
            dec_ctrl = '{1'b1, 1'b0, 1'b0, 1'b1, WB_ALU};
         end
         OPC_AUIPC: begin
            imm_type = IMM_U;
            dec_ctrl = '{1'b1, 1'b0, 1'b0, 1'b1, WB_PCIMM};
         end
         default: ;
      endcase
   end

   // Immediate generation; R-type and unknown opcodes yield zero.
   always_comb begin
      imm32 = '0;
      case (imm_type)
         IMM_I:   imm32 = {{20{if_inst[31]}}, if_inst[31:20]};
         IMM_S:   imm32 = {{20{if_inst[31]}}, if_inst[31:25], if_inst[11:7]};
         IMM_B:   imm32 = {{19{if_inst[31]}}, if_inst[31], if_inst[7],
                           if_inst[30:25], if_inst[11:8], 1'b0};
         IMM_U:   imm32 = {if_inst[31:12], 12'b0};
         IMM_J:   imm32 = {{11{if_inst[31]}}, if_inst[31], if_inst[19:12],
                           if_inst[20], if_inst[30:21], 1'b0};
         default: imm32 = '0;
      endcase
   end

   assign dec_imm = REG_WIDTH'($signed(imm32));
   assign dec_rd  = dec_ctrl.reg_wr ? if_inst[11:7] : '0;

   // Register file next state: one write port, x0 never written.
   always_comb begin
      regs_d = regs_q;
      if (wb_wr_en && wb_rd != '0) regs_d[wb_rd] = wb_data;
   end

   // Register file read with write-through bypass of the same-cycle WB write.
   always_comb begin
      rf_rs1 = (wb_wr_en && wb_rd == rs1 && rs1 != '0) ? wb_data : regs_q[rs1];
      rf_rs2 = (wb_wr_en && wb_rd == rs2 && rs2 != '0) ? wb_data : regs_q[rs2];
   end

   // Forwarded operands; index 0 and unread sources are forced to zero so
   // EX can treat LUI as imm + 0.
   always_comb begin
      rs1v = (rs1_used && rs1 != '0) ? fwd_mux(fwd_sel1, rf_rs1) : '0;
      rs2v = (rs2_used && rs2 != '0) ? fwd_mux(fwd_sel2, rf_rs2) : '0;
   end

   // Branch condition: funct3[2] picks less-than vs equality, funct3[1]
   // unsigned compare, funct3[0] inverts; 010/011 are not branches.
   always_comb begin
      br_taken = 1'b0;
      if (funct3[2]) begin
         if (funct3[1]) br_taken = (rs1v < rs2v) ^ funct3[0];
         else           br_taken = ($signed(rs1v) < $signed(rs2v)) ^ funct3[0];
      end else if (!funct3[1]) begin
         br_taken = (rs1v == rs2v) ^ funct3[0];
      end
   end

   // Handshake and load-use hazard.
   assign adv      = id_ex_bus.ex_ready || !id_ex_q.valid;
   assign load_use = if_valid && ex_is_load && id_ex_q.valid && ex_rd != '0 &&
                     ((rs1_used && ex_rd == rs1) || (rs2_used && ex_rd == rs2));
   assign id_ready = adv && !load_use;
   assign transfer = if_valid && id_ready;

   // Redirect only on an actual transfer, never while reset is asserted.
   assign jalr_sum  = rs1v + dec_imm;
   assign pc_sel    = reset_n && transfer && (is_jal || is_jalr || (is_branch && br_taken));
   assign pc_target = is_jalr ? (PC_WIDTH'(jalr_sum) & ~PC_WIDTH'(1))
                              : (if_pc + PC_WIDTH'(dec_imm));

   // ID/EX next state: load on advance (bubble clears ctrl/rd), else hold.
   always_comb begin
      id_ex_d = id_ex_q;
      if (adv) begin
         id_ex_d.valid    = transfer;
         id_ex_d.pc       = if_pc;
         id_ex_d.rs1_data = rs1v;
         id_ex_d.rs2_data = rs2v;
         id_ex_d.imm      = dec_imm;
         id_ex_d.funct    = {if_inst[30], funct3};
         id_ex_d.rd       = transfer ? dec_rd : '0;
         id_ex_d.ctrl     = transfer ? dec_ctrl : '0;
      end
   end

   // Stall counter next state: counts load-use bubbles actually inserted.
   always_comb begin
      stall_cnt_d = stall_cnt_q;
      if (load_use && adv && stall_cnt_q != '1) stall_cnt_d = stall_cnt_q + 1'b1;
   end

   // Pipeline register and stall counter with synchronous reset.
   always_ff @(posedge clk) begin
      // NOTE: non-blocking assignments make every flop sample pre-edge values,
      // independent of statement order or of other clocked blocks.
      if (!reset_n) begin
         id_ex_q     <= '0;
         stall_cnt_q <= '0;
      end else begin
         id_ex_q     <= id_ex_d;
         stall_cnt_q <= stall_cnt_d;
      end
   end

   // Register file storage.
   always_ff @(posedge clk) begin
      // NOTE: this storage is deliberately reset so reads after reset are
      // defined; that keeps it in flops rather than a RAM macro.
      if (!reset_n) begin
         for (int i = 0; i < NUM_REG; i++) regs_q[i] <= '0;
      end else begin
         regs_q <= regs_d;
      end
   end

   assign id_ex_bus.id_ex_valid    = id_ex_q.valid;
   assign id_ex_bus.id_ex_pc       = id_ex_q.pc;
   assign id_ex_bus.id_ex_rs1_data = id_ex_q.rs1_data;
   assign id_ex_bus.id_ex_rs2_data = id_ex_q.rs2_data;
   assign id_ex_bus.id_ex_imm      = id_ex_q.imm;
   assign id_ex_bus.id_ex_rd       = id_ex_q.rd;
   assign id_ex_bus.id_ex_funct    = id_ex_q.funct;
   assign id_ex_bus.id_ex_ctrl     = id_ex_q.ctrl;
   assign stall_cnt                = stall_cnt_q;

endmodule

// File: tb/tb_stage_id_pipe.sv
// Directed bench for stage_id_pipe: a vector table for single-instruction
// decode/forward/branch cases, plus hand sequences for load-use, backpressure,
// reset mid-hold and stall-counter saturation (counter narrowed to 4 bits).
module tb_stage_id_pipe;
   localparam int SCW = 4;

   logic           clk = 1'b0;
   logic           reset_n;
   logic           if_valid;
   logic           id_ready;
   logic [31:0]    if_pc;
   logic [31:0]    if_inst;
   logic           wb_wr_en;
   logic [4:0]     wb_rd;
   logic [31:0]    wb_data;
   logic [1:0]     fwd_sel1;
   logic [1:0]     fwd_sel2;
   logic [31:0]    ex_fwd_data;
   logic [31:0]    mem_fwd_data;
   logic           ex_is_load;
   logic [4:0]     ex_rd;
   logic           pc_sel;
   logic [31:0]    pc_target;
   logic [SCW-1:0] stall_cnt;

   int n_vec = 0;
   int n_bad = 0;

   always #5 clk = ~clk;

   stage_id_pipe_if bus ();

   stage_id_pipe #(.STALL_CNT_WIDTH(SCW)) dut (
      .clk          (clk),
      .reset_n      (reset_n),
      .if_valid     (if_valid),
      .id_ready     (id_ready),
      .if_pc        (if_pc),
      .if_inst      (if_inst),
      .wb_wr_en     (wb_wr_en),
      .wb_rd        (wb_rd),
      .wb_data      (wb_data),
      .fwd_sel1     (fwd_sel1),
      .fwd_sel2     (fwd_sel2),
      .ex_fwd_data  (ex_fwd_data),
      .mem_fwd_data (mem_fwd_data),
      .ex_is_load   (ex_is_load),
      .ex_rd        (ex_rd),
      .pc_sel       (pc_sel),
      .pc_target    (pc_target),
      .id_ex_bus    (bus),
      .stall_cnt    (stall_cnt)
   );

   typedef struct {
      string       name;
      logic [31:0] pc;
      logic [31:0] inst;
      logic [1:0]  fs1;
      logic [1:0]  fs2;
      logic [31:0] exf;
      logic [31:0] memf;
      logic        wbe;
      logic [4:0]  wbrd;
      logic [31:0] wbd;
      logic        e_pcsel;
      logic [31:0] e_tgt;
      logic [31:0] e_rs1;
      logic [31:0] e_rs2;
      logic [31:0] e_imm;
      logic [4:0]  e_rd;
      logic [3:0]  e_funct;
      logic [5:0]  e_ctrl;
   } vec_t;

   vec_t vecs [13];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic drive(input logic [31:0] pc, input logic [31:0] inst);
      if_valid = 1'b1;
      if_pc    = pc;
      if_inst  = inst;
      fwd_sel1 = 2'b00;
      fwd_sel2 = 2'b00;
      wb_wr_en = 1'b0;
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check_idex(input string tag, input logic [31:0] pc,
                             input logic [31:0] rs1, input logic [31:0] rs2,
                             input logic [31:0] imm, input logic [4:0] rd,
                             input logic [3:0] funct, input logic [5:0] ctrl);
      check({tag, ".valid"}, 32'(bus.id_ex_valid), 32'd1);
      check({tag, ".pc"}, bus.id_ex_pc, pc);
      check({tag, ".rs1"}, bus.id_ex_rs1_data, rs1);
      check({tag, ".rs2"}, bus.id_ex_rs2_data, rs2);
      check({tag, ".imm"}, bus.id_ex_imm, imm);
      check({tag, ".rd"}, 32'(bus.id_ex_rd), 32'(rd));
      check({tag, ".funct"}, 32'(bus.id_ex_funct), 32'(funct));
      check({tag, ".ctrl"}, 32'(bus.id_ex_ctrl), 32'(ctrl));
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

   initial begin
      //           name     pc        inst          fs1   fs2   exf           memf   wbe   wbrd wbd          pcsel tgt           rs1           rs2           imm           rd    funct  ctrl
      vecs[0]  = '{"addi",  32'h000, 32'h00500093, 2'd0, 2'd0, 32'h0,        32'h0, 1'b1, 5'd2, 32'd7,       1'b0, 32'h0,        32'h0,        32'h0,        32'h5,        5'd1, 4'h0, 6'b100100};
      vecs[1]  = '{"byp",   32'h004, 32'h00018233, 2'd0, 2'd0, 32'h0,        32'h0, 1'b1, 5'd3, 32'hDEAD,    1'b0, 32'h0,        32'hDEAD,     32'h0,        32'h0,        5'd4, 4'h0, 6'b100000};
      vecs[2]  = '{"wr_x0", 32'h008, 32'h00018233, 2'd0, 2'd0, 32'h0,        32'h0, 1'b1, 5'd0, 32'h55,      1'b0, 32'h0,        32'hDEAD,     32'h0,        32'h0,        5'd4, 4'h0, 6'b100000};
      vecs[3]  = '{"rd_x0", 32'h00C, 32'h00300233, 2'd1, 2'd0, 32'h99,       32'h0, 1'b0, 5'd0, 32'h0,       1'b0, 32'h0,        32'h0,        32'hDEAD,     32'h0,        5'd4, 4'h0, 6'b100000};
      vecs[4]  = '{"beq_t", 32'h100, 32'h00208863, 2'd1, 2'd0, 32'd7,        32'h0, 1'b0, 5'd0, 32'h0,       1'b1, 32'h110,      32'd7,        32'd7,        32'h10,       5'd0, 4'h0, 6'b000000};
      vecs[5]  = '{"beq_n", 32'h100, 32'h00208863, 2'd1, 2'd0, 32'd7,        32'h0, 1'b1, 5'd2, 32'd8,       1'b0, 32'h110,      32'd7,        32'd8,        32'h10,       5'd0, 4'h0, 6'b000000};
      vecs[6]  = '{"bltu",  32'h100, 32'h0020E863, 2'd1, 2'd2, 32'hFFFFFFFF, 32'h1, 1'b0, 5'd0, 32'h0,       1'b0, 32'h110,      32'hFFFFFFFF, 32'h1,        32'h10,       5'd0, 4'h6, 6'b000000};
      vecs[7]  = '{"blt",   32'h100, 32'h0020C863, 2'd1, 2'd2, 32'hFFFFFFFF, 32'h1, 1'b0, 5'd0, 32'h0,       1'b1, 32'h110,      32'hFFFFFFFF, 32'h1,        32'h10,       5'd0, 4'h4, 6'b000000};
      vecs[8]  = '{"jalr",  32'h300, 32'h008100E7, 2'd3, 2'd0, 32'h0,        32'h0, 1'b1, 5'd2, 32'h203,     1'b1, 32'h20A,      32'h203,      32'h0,        32'h8,        5'd1, 4'h0, 6'b100110};
      vecs[9]  = '{"jal",   32'h200, 32'hFF9FF0EF, 2'd0, 2'd0, 32'h0,        32'h0, 1'b0, 5'd0, 32'h0,       1'b1, 32'h1F8,      32'h0,        32'h0,        32'hFFFFFFF8, 5'd1, 4'hF, 6'b100010};
      vecs[10] = '{"sw",    32'h204, 32'hFE20AE23, 2'd0, 2'd0, 32'h0,        32'h0, 1'b0, 5'd0, 32'h0,       1'b0, 32'h0,        32'h0,        32'h203,      32'hFFFFFFFC, 5'd0, 4'hA, 6'b010100};
      vecs[11] = '{"lui",   32'h208, 32'h123453B7, 2'd0, 2'd0, 32'h0,        32'h0, 1'b0, 5'd0, 32'h0,       1'b0, 32'h0,        32'h0,        32'h0,        32'h12345000, 5'd7, 4'h5, 6'b100100};
      vecs[12] = '{"unkn",  32'h20C, 32'h0000028B, 2'd0, 2'd0, 32'h0,        32'h0, 1'b0, 5'd0, 32'h0,       1'b0, 32'h0,        32'h0,        32'h0,        32'h0,        5'd0, 4'h0, 6'b000000};

      // Reset with a JAL presented: no redirect while reset is asserted.
      reset_n      = 1'b0;
      bus.ex_ready = 1'b1;
      ex_is_load   = 1'b0;
      ex_rd        = 5'd0;
      ex_fwd_data  = 32'h0;
      mem_fwd_data = 32'h0;
      wb_rd        = 5'd0;
      wb_data      = 32'h0;
      drive(32'h200, 32'hFF9FF0EF);
      #2;
      check("rst.pc_sel", 32'(pc_sel), 32'd0);
      tick();
      check("rst.valid", 32'(bus.id_ex_valid), 32'd0);
      check("rst.ctrl", 32'(bus.id_ex_ctrl), 32'd0);
      check("rst.rd", 32'(bus.id_ex_rd), 32'd0);
      check("rst.imm", bus.id_ex_imm, 32'd0);
      check("rst.stall_cnt", 32'(stall_cnt), 32'd0);
      reset_n = 1'b1;

      // Single-instruction vectors, each transferred with EX ready.
      for (int i = 0; i < 13; i++) begin
         drive(vecs[i].pc, vecs[i].inst);
         fwd_sel1     = vecs[i].fs1;
         fwd_sel2     = vecs[i].fs2;
         ex_fwd_data  = vecs[i].exf;
         mem_fwd_data = vecs[i].memf;
         wb_wr_en     = vecs[i].wbe;
         wb_rd        = vecs[i].wbrd;
         wb_data      = vecs[i].wbd;
         #2;
         check({vecs[i].name, ".id_ready"}, 32'(id_ready), 32'd1);
         check({vecs[i].name, ".pc_sel"}, 32'(pc_sel), 32'(vecs[i].e_pcsel));
         if (vecs[i].e_pcsel) check({vecs[i].name, ".pc_target"}, pc_target, vecs[i].e_tgt);
         tick();
         check_idex(vecs[i].name, vecs[i].pc, vecs[i].e_rs1, vecs[i].e_rs2,
                    vecs[i].e_imm, vecs[i].e_rd, vecs[i].e_funct, vecs[i].e_ctrl);
      end

      // Load-use: LW x5 in ID/EX, ADD x6,x5,x1 in ID; WB writes x5 during the stall.
      drive(32'h400, 32'h00128333);
      ex_is_load = 1'b1;
      ex_rd      = 5'd5;
      wb_wr_en   = 1'b1;
      wb_rd      = 5'd5;
      wb_data    = 32'h1234;
      #2;
      check("lu.id_ready", 32'(id_ready), 32'd0);
      check("lu.pc_sel", 32'(pc_sel), 32'd0);
      tick();
      check("lu.bubble_valid", 32'(bus.id_ex_valid), 32'd0);
      check("lu.bubble_ctrl", 32'(bus.id_ex_ctrl), 32'd0);
      check("lu.stall_cnt", 32'(stall_cnt), 32'd1);
      // ex_is_load still high, but the bubble in ID/EX must not stall again.
      wb_wr_en = 1'b0;
      #2;
      check("lu.issue_ready", 32'(id_ready), 32'd1);
      tick();
      check_idex("lu.issue", 32'h400, 32'h1234, 32'h0, 32'h0, 5'd6, 4'h0, 6'b100000);
      check("lu.stall_cnt_after", 32'(stall_cnt), 32'd1);

      // Backpressure: EX not ready, ID/EX holds ADD x6 for 3 cycles.
      ex_is_load   = 1'b0;
      bus.ex_ready = 1'b0;
      drive(32'h200, 32'hFF9FF0EF);
      #2;
      check("bp.id_ready", 32'(id_ready), 32'd0);
      check("bp.pc_sel", 32'(pc_sel), 32'd0);
      for (int c = 0; c < 3; c++) begin
         tick();
         check_idex("bp.hold", 32'h400, 32'h1234, 32'h0, 32'h0, 5'd6, 4'h0, 6'b100000);
         check("bp.stall_cnt", 32'(stall_cnt), 32'd1);
         // Hazard while not advancing must not count as a stall.
         drive(32'h404, 32'h000303B3);
         ex_is_load = 1'b1;
         ex_rd      = 5'd6;
      end

      // Reset mid-hold with a JAL presented.
      drive(32'h200, 32'hFF9FF0EF);
      ex_is_load = 1'b0;
      reset_n    = 1'b0;
      #2;
      check("rsthold.pc_sel", 32'(pc_sel), 32'd0);
      tick();
      check("rsthold.valid", 32'(bus.id_ex_valid), 32'd0);
      check("rsthold.stall_cnt", 32'(stall_cnt), 32'd0);
      check("rsthold.rd", 32'(bus.id_ex_rd), 32'd0);
      reset_n      = 1'b1;
      bus.ex_ready = 1'b1;

      // Register file was cleared: x3 reads 0 now.
      drive(32'h500, 32'h00018233);
      #2;
      check("rf_clr.id_ready", 32'(id_ready), 32'd1);
      tick();
      check_idex("rf_clr", 32'h500, 32'h0, 32'h0, 32'h0, 5'd4, 4'h0, 6'b100000);

      // Saturation: alternate issue/stall 20 times; 4-bit counter stops at 15.
      for (int i = 0; i < 20; i++) begin
         drive(32'h500, 32'h00018233);
         ex_is_load = 1'b0;
         tick();
         drive(32'h504, 32'h00128333);
         ex_is_load = 1'b1;
         ex_rd      = 5'd5;
         tick();
         check("sat.stall_cnt", 32'(stall_cnt), (i + 1 > 15) ? 32'd15 : 32'(i + 1));
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end
endmodule

// File: doc/stage_id_pipe.md
Name: stage_id_pipe

Overview:
- Parametrised instruction-decode stage for the RV32I 5-stage pipeline, successor to the combinational ID stage.
- Contains:
  - integer register file with write-through bypass
  - immediate generator (I/S/B/U/J)
  - 3-source forwarding muxes
  - branch/jump resolution in ID
  - load-use hazard stall logic
  - registered ID/EX pipeline register with valid/ready handshake
  - stall performance counter
- Sits between the IF/ID register and stage EX.

Parameters:
- NUM_REG, 32, number of architectural registers; x0 reads as 0 and is never written.
- REG_ADDR_WIDTH, 5, register index width (clog2(NUM_REG)).
- REG_WIDTH, 32, data/register width.
- PC_WIDTH, 32, program counter width.
- INST_WIDTH, 32, instruction width.
- STALL_CNT_WIDTH, 16, width of the saturating stall counter.

Ports:
- clk  in  1  clock
- reset_n  in  1  synchronous active-low reset, sampled on rising clk
- if_valid  in  1  IF/ID holds a valid instruction
- id_ready  out  1  ID accepts the IF/ID instruction this cycle
- if_pc  in  PC_WIDTH  IF/ID PC
- if_inst  in  INST_WIDTH  IF/ID instruction
- wb_wr_en  in  1  MEM/WB RegWrite
- wb_rd  in  REG_ADDR_WIDTH  MEM/WB destination index
- wb_data  in  REG_WIDTH  MEM/WB write data
- fwd_sel1, fwd_sel2  in  2 each  00 regfile, 01 ex_fwd_data, 10 mem_fwd_data, 11 wb_data
- ex_fwd_data  in  REG_WIDTH  EX/MEM ALU result
- mem_fwd_data  in  REG_WIDTH  DMEM read data
- ex_is_load  in  1  instruction currently in ID/EX is a load
- ex_rd  in  REG_ADDR_WIDTH  its destination
- ex_ready  in  1  EX accepts ID/EX contents
- pc_sel  out  1  redirect fetch to pc_target (combinational)
- pc_target  out  PC_WIDTH  branch/JAL/JALR target
- id_ex_valid  out  1  ID/EX register valid
- id_ex_pc  out  PC_WIDTH  registered PC
- id_ex_rs1_data, id_ex_rs2_data  out  REG_WIDTH each  registered forwarded operands
- id_ex_imm  out  REG_WIDTH  registered immediate
- id_ex_rd  out  REG_ADDR_WIDTH  registered destination (0 if no write)
- id_ex_funct  out  4  {inst[30], funct3}
- id_ex_ctrl  out  6  {reg_wr, mem_wr, mem_rd, alu_src_imm, wb_sel[1:0]}
- stall_cnt  out  STALL_CNT_WIDTH  saturating count of load-use stall cycles

Behaviour:
- Reset (reset_n=0 at posedge):
  - id_ex_valid=0; all id_ex_* data/ctrl =0; stall_cnt=0.
  - Register file is cleared to 0 by the same synchronous reset.
  - Combinational outputs are don't-care while reset is asserted, except that pc_sel must be 0.
- Register file:
  - Write on posedge when wb_wr_en && wb_rd!=0.
  - Same-cycle read of wb_rd returns wb_data (write-through bypass).
  - x0 is always 0.
- Decode:
  - opcode if_inst[6:0] selects imm type: I (OP-IMM, LOAD, JALR), S, B, U (LUI, AUIPC), J.
  - Sign-extend to REG_WIDTH. R-type imm=0.
  - Unknown opcode decodes as NOP: ctrl=0, rd=0.
- Operand select:
  - rs1v/rs2v come from the fwd_sel mux.
  - rs1/rs2 index 0 forces 0 regardless of fwd_sel.
- Hazard: load_use = if_valid && ex_is_load && id_ex_valid && ex_rd!=0 && (ex_rd==rs1 used || ex_rd==rs2 used).
  - rs2 counts as used only for R, S, B types.
- Handshake:
  - adv = ex_ready || !id_ex_valid.
  - id_ready = adv && !load_use.
  - Transfer when if_valid && id_ready: capture decoded fields and set id_ex_valid=1.
  - If adv but no transfer (bubble or !if_valid): id_ex_valid=0 and ctrl cleared.
  - If !adv: hold all ID/EX contents unchanged.
- Branch resolution:
  - Evaluated only on transfer.
  - BEQ/BNE/BLT/BGE/BLTU/BGEU compare rs1v and rs2v; signedness is taken from funct3[1].
  - pc_sel=1 on a taken branch or JAL (target=if_pc+imm) or JALR (target=(rs1v+imm)&~1).
  - pc_sel=0 otherwise, including while stalled.
  - JAL/JALR write if_pc+4, selected by wb_sel=10.
- Stall counter: +1 on each cycle with load_use && adv; saturates at all-ones.
- Simultaneous events:
  - wb write to rsX in the same cycle as a stall: the bypass still applies the following cycle.
  - reset mid-stall clears id_ex_valid immediately; no pending redirect survives.

Test Plan:
- Reset then ADDI x1,x0,5 (0x00500093), if_valid=1, ex_ready=1 -> next cycle id_ex_valid=1, id_ex_imm=5, id_ex_rd=1, ctrl reg_wr=1 alu_src_imm=1.
- Bypass: wb_wr_en=1, wb_rd=3, wb_data=0xDEAD same cycle as ADD x4,x3,x0 -> id_ex_rs1_data=0xDEAD; write to x0 then read x0 -> 0.
- Load-use: id_ex holds LW x5 (ex_is_load=1, ex_rd=5), ID has ADD x6,x5,x1 -> id_ready=0 for 1 cycle, bubble (id_ex_valid=0), stall_cnt=1; next cycle ADD issues.
- BEQ x1,x2,+16 at pc=0x100 with fwd_sel1=01 ex_fwd_data=7 and x2=7 -> pc_sel=1, pc_target=0x110. With x2=8 -> pc_sel=0. BLTU with 0xFFFFFFFF vs 1 -> not taken; BLT -> taken.
- JALR x1,8(x2) with x2=0x203 -> pc_target=0x20A, id_ex_rd=1, wb_sel=10.
- Backpressure: ex_ready=0 with id_ex_valid=1 -> id_ready=0, all id_ex_* stable over 3 cycles; assert reset_n=0 mid-hold -> id_ex_valid=0, stall_cnt=0 at next edge.
